// File: rtl/fp32_link_host.sv
// ---------------------------------------------------------------------------
// fp32_link_host
//
// Host-side initiator for the byte-wide pin interface of the
// tt_um_32_bit_fp_ALU_S_M chip. A single FP32 add/subtract request is
// taken on a valid/ready port and sent to the chip as eight operand bytes
// (A[7:0] first, B[31:24] last). The four result bytes that the chip
// strobes back are collected LSB-first and returned on a valid/ready
// response port. If the chip stays silent for too long, the response is
// returned with rsp_err set.
//
// Optional feature: define FP32_LINK_HOST_TXN_CNT_EN to add a 16-bit
// counter of error-free completed transactions on txn_count. Without the
// macro, txn_count is tied to zero and has no flops behind it.
//
// Parameters:
//   TIMEOUT_CYCLES  non-strobe cycles allowed in WAIT/RECV before abort
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake; req_a, req_b operands, req_op 0=add 1=sub
//   rsp_valid/ready response handshake; rsp_data result, rsp_err timeout flag
//   pin_ui          to chip ui_in  (operand byte)
//   pin_uio         to chip uio_in (bit0 strobe, bit1 op, bit2 first byte)
//   pin_uo          from chip uo_out  (result byte)
//   pin_uio_out     from chip uio_out (bit0 result strobe)
//   txn_count       completed error-free transactions (optional)
// ---------------------------------------------------------------------------
module fp32_link_host #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  pin_ui,
    output logic [7:0]  pin_uio,
    input  logic [7:0]  pin_uo,
    input  logic [7:0]  pin_uio_out,
    output logic [15:0] txn_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [63:0]      shift_reg;
    logic             op_reg;
    logic [3:0]       idx_reg;
    logic [CNT_W-1:0] tmo_reg;

    // Only the strobe bit of uio_out carries meaning for the host.
    logic unused_uio_bits;
    assign unused_uio_bits = ^pin_uio_out[7:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            shift_reg <= '0;
            op_reg    <= 1'b0;
            idx_reg   <= '0;
            tmo_reg   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            pin_ui    <= '0;
            pin_uio   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Byte 1 goes straight onto the pins in the cycle
                        // after acceptance, so the operand register is
                        // loaded already advanced by one byte.
                        shift_reg <= {8'h00, req_b, req_a[31:8]};
                        op_reg    <= req_op;
                        rsp_data  <= '0;
                        pin_ui    <= req_a[7:0];
                        pin_uio   <= {5'b00000, 1'b1, req_op, 1'b1};
                        idx_reg   <= 4'd1;
                        req_ready <= 1'b0;
                        state_reg <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (idx_reg == 4'd8) begin
                        // All eight bytes have been on the pins; release.
                        pin_ui    <= '0;
                        pin_uio   <= '0;
                        idx_reg   <= '0;
                        tmo_reg   <= '0;
                        state_reg <= S_WAIT;
                    end else begin
                        pin_ui    <= shift_reg[7:0];
                        pin_uio   <= {5'b00000, 1'b0, op_reg, 1'b1};
                        shift_reg <= {8'h00, shift_reg[63:8]};
                        idx_reg   <= idx_reg + 4'd1;
                    end
                end

                S_WAIT, S_RECV: begin
                    if (pin_uio_out[0]) begin
                        // Result byte k lands in rsp_data[8k+7:8k].
                        rsp_data[{idx_reg[1:0], 3'b000} +: 8] <= pin_uo;
                        tmo_reg <= '0;
                        if (idx_reg == 4'd3) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            idx_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            idx_reg   <= idx_reg + 4'd1;
                            state_reg <= S_RECV;
                        end
                    end else if (tmo_reg == TMO_LAST) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th in a row;
                        // hand back whatever bytes arrived, flagged.
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        idx_reg   <= '0;
                        tmo_reg   <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        tmo_reg <= tmo_reg + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (rsp_ready) begin
                        // req_ready rises only after rsp_valid has fallen,
                        // so request and response never overlap.
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP32_LINK_HOST_TXN_CNT_EN
    logic [15:0] txn_count_reg;

    // Counts error-free response handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count_reg <= '0;
        end else if (state_reg == S_DONE && rsp_ready && !rsp_err) begin
            txn_count_reg <= txn_count_reg + 16'd1;
        end
    end

    assign txn_count = txn_count_reg;
`else
    assign txn_count = 16'd0;
`endif

endmodule

// File: tb/tb_fp32_link_host.sv
// ---------------------------------------------------------------------------
// tb_fp32_link_host
//
// Directed bench for fp32_link_host. A behavioural chip model drives the
// result bytes; expected operand bytes, results and cycle counts are
// hand-derived from the request values.
// ---------------------------------------------------------------------------
module tb_fp32_link_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  pin_ui;
    logic [7:0]  pin_uio;
    logic [7:0]  pin_uo;
    logic [7:0]  pin_uio_out;
    logic [15:0] txn_count;

    int total = 0;
    int bad   = 0;
    int exp_txn = 0;

    always #5 clk = ~clk;

    fp32_link_host #(
        .TIMEOUT_CYCLES(64),
        .CNT_W(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .pin_ui(pin_ui),
        .pin_uio(pin_uio),
        .pin_uo(pin_uo),
        .pin_uio_out(pin_uio_out),
        .txn_count(txn_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and check the eight operand bytes on the pins.
    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [63:0] ops;
        logic [7:0]  exp_uio;
        ops = {b, a};
        req_a = a;
        req_b = b;
        req_op = op;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1'b1);
        tick;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = 1'b0;
        chk("req_ready_drop", req_ready, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_uio = {5'b00000, (k == 0), op, 1'b1};
            chk("pin_ui_byte", pin_ui, ops[8*k +: 8]);
            chk("pin_uio_byte", pin_uio, exp_uio);
            tick;
        end
        chk("pin_ui_released", pin_ui, 8'h00);
        chk("pin_uio_released", pin_uio, 8'h00);
    endtask

    // Chip model: strobe nbytes of res back, with gap idle cycles between.
    // Junk on pin_uo during gaps must not be captured.
    task automatic chip_return(input logic [31:0] res, input int nbytes, input int gap);
        for (int k = 0; k < nbytes; k++) begin
            chk("rsp_valid_early", rsp_valid, 1'b0);
            pin_uo = res[8*k +: 8];
            pin_uio_out = 8'h01;
            tick;
            pin_uio_out = 8'h00;
            pin_uo = 8'hEE;
            if (k < nbytes - 1) begin
                repeat (gap) tick;
            end
        end
        pin_uo = 8'h00;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            tick;
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1'b1);
    endtask

    task automatic finish_rsp(input logic [31:0] exp_data, input logic exp_err, input string name);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", rsp_valid, 1'b0);
        chk("rsp_err_cleared", rsp_err, 1'b0);
        chk("req_ready_back", req_ready, 1'b1);
`ifdef FP32_LINK_HOST_TXN_CNT_EN
        if (!exp_err) exp_txn++;
`endif
        chk("txn_count", txn_count, exp_txn);
        $display("txn %s: data=%08h err=%0d count=%0d", name, exp_data, exp_err, exp_txn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = 1'b0;
        rsp_ready = 1'b0;
        pin_uo = '0;
        pin_uio_out = '0;
        repeat (3) tick;

        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_pin_ui", pin_ui, 8'h00);
        chk("rst_pin_uio", pin_uio, 8'h00);
        chk("rst_txn_count", txn_count, 16'h0);
        rst = 1'b0;
        tick;

        // 1.0 + 2.0 = 3.0, back-to-back result strobes: rsp_valid at cycle 13.
        send_req(32'h3F800000, 32'h40000000, 1'b0);
        chip_return(32'h40400000, 4, 0);
        chk("latency_valid", rsp_valid, 1'b1);
        finish_rsp(32'h40400000, 1'b0, "add_1_2");

        // 5.0 - 3.0 = 2.0 with three idle cycles between result bytes.
        send_req(32'h40A00000, 32'h40400000, 1'b1);
        chip_return(32'h40000000, 4, 3);
        chk("gapped_valid", rsp_valid, 1'b1);
        finish_rsp(32'h40000000, 1'b0, "sub_5_3");

        // Timeout after two bytes; exactly 64 silent cycles to rsp_valid.
        send_req(32'h3F800000, 32'h3F800000, 1'b0);
        chip_return(32'h0000BBAA, 2, 0);
        wait_valid(200, n);
        chk("timeout_cycles", n, 64);
        chk("timeout_err", rsp_err, 1'b1);
        // A strobe while in DONE must leave the result untouched.
        pin_uo = 8'h77;
        pin_uio_out = 8'h01;
        tick;
        pin_uio_out = 8'h00;
        pin_uo = 8'h00;
        chk("done_strobe_ignored", rsp_data, 32'h0000BBAA);
        finish_rsp(32'h0000BBAA, 1'b1, "timeout");

        // Backpressure: 3.0 + 1.0 = 4.0 held for 20 cycles.
        send_req(32'h40400000, 32'h3F800000, 1'b0);
        chip_return(32'h40800000, 4, 0);
        for (int i = 0; i < 20; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 32'h40800000);
            chk("bp_req_ready", req_ready, 1'b0);
            tick;
        end
        finish_rsp(32'h40800000, 1'b0, "backpressure");

        // Next request straight after release: 1.0 + 1.0 = 2.0.
        send_req(32'h3F800000, 32'h3F800000, 1'b0);
        chip_return(32'h40000000, 4, 1);
        wait_valid(10, n);
        finish_rsp(32'h40000000, 1'b0, "after_bp");

        // Reset in the middle of SEND, once byte 3 is on the pins.
        req_a = 32'h12345678;
        req_b = 32'h9ABCDEF0;
        req_op = 1'b1;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        chk("midsend_byte3", pin_ui, 8'h34);
        rst = 1'b1;
        #1;
        chk("rst_async_pin_ui", pin_ui, 8'h00);
        chk("rst_async_pin_uio", pin_uio, 8'h00);
        chk("rst_async_req_ready", req_ready, 1'b1);
        tick;
        tick;
        rst = 1'b0;
        exp_txn = 0;
        chk("post_rst_txn_count", txn_count, 16'h0);
        // Strobes arriving in IDLE are ignored.
        for (int i = 0; i < 4; i++) begin
            pin_uo = 8'hAB;
            pin_uio_out = 8'h01;
            tick;
            chk("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk("post_rst_pin_uio", pin_uio, 8'h00);
            chk("post_rst_req_ready", req_ready, 1'b1);
        end
        pin_uio_out = 8'h00;
        pin_uo = 8'h00;
        $display("txn reset_mid_send: aborted");

        // Recovery: -2.0 + 1.0 = -1.0.
        send_req(32'hC0000000, 32'h3F800000, 1'b0);
        chip_return(32'hBF800000, 4, 2);
        chk("recover_valid", rsp_valid, 1'b1);
        finish_rsp(32'hBF800000, 1'b0, "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
